// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants, state encoding and helpers for multdiv
package multdiv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_WIDTH  = $clog2(ITER_COUNT) + 1;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - x) : x;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU with add/subtract (signed overflow), logic ops and shifts
module alu
    import multdiv_pkg::*;
(
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        overflow
);

    logic        sub;
    logic [31:0] b_eff;
    logic [31:0] sum;

    assign sub   = (ctrl_ALUopcode == ALU_SUB);
    assign b_eff = sub ? ~data_operandB : data_operandB;
    assign sum   = data_operandA + b_eff + {31'b0, sub};

    always_comb begin
        data_result = sum;
        overflow    = 1'b0;
        case (ctrl_ALUopcode)
            ALU_ADD, ALU_SUB: begin
                data_result = sum;
                overflow    = (data_operandA[31] == b_eff[31]) && (sum[31] != data_operandA[31]);
            end
            5'b00010: data_result = data_operandA & data_operandB;
            5'b00011: data_result = data_operandA | data_operandB;
            5'b00100: data_result = data_operandA << ctrl_shiftamt;
            5'b00101: data_result = $signed(data_operandA) >>> ctrl_shiftamt;
            default:  data_result = sum;
        endcase
    end

endmodule

// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative signed multiply/divide, 33-cycle fixed latency, one ALU op per cycle
module multdiv
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam logic [CNT_WIDTH-1:0] CNT_DONE = CNT_WIDTH'(ITER_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ITER_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            acc_q, acc_d;
    logic [31:0]            lo_q, lo_d;
    logic [31:0]            opb_q, opb_d;
    logic [31:0]            result_q, result_d;
    logic                   exc_q, exc_d;
    logic                   neg_q, neg_d;
    logic                   dz_q, dz_d;
    logic                   dovf_q, dovf_d;

    logic        start;
    logic [31:0] rem_shift;
    logic [31:0] alu_a;
    logic [4:0]  alu_op;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic [31:0] mul_sum;
    logic        mul_sign;
    logic        borrow;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign rem_shift = {acc_q[30:0], lo_q[31]};

    // Multiplier's MSB carries weight -2^31, so the last multiply step subtracts.
    assign alu_a  = (state_q == ST_DIV) ? rem_shift : acc_q;
    assign alu_op = ((state_q == ST_DIV) || (cnt_q == CNT_LAST)) ? ALU_SUB : ALU_ADD;

    alu u_alu (
        .data_operandA  (alu_a),
        .data_operandB  (opb_q),
        .ctrl_ALUopcode (alu_op),
        .ctrl_shiftamt  (5'd0),
        .data_result    (alu_res),
        .overflow       (alu_ovf)
    );

    // True 33-bit sign of the partial sum, and unsigned borrow of remainder minus divisor.
    assign mul_sum  = lo_q[0] ? alu_res : acc_q;
    assign mul_sign = lo_q[0] ? (alu_res[31] ^ alu_ovf) : acc_q[31];
    assign borrow   = alu_res[31] ^ alu_ovf ^ rem_shift[31] ^ opb_q[31];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        exc_d    = exc_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        dovf_d   = dovf_q;

        case (state_q)
            ST_MULT: begin
                if (cnt_q != CNT_DONE) begin
                    acc_d = {mul_sign, mul_sum[31:1]};
                    lo_d  = {mul_sum[0], lo_q[31:1]};
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    result_d = lo_q;
                    exc_d    = (acc_q != {32{lo_q[31]}});
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                if (cnt_q != CNT_DONE) begin
                    acc_d = borrow ? rem_shift : alu_res;
                    lo_d  = {lo_q[30:0], ~borrow};
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    if (dz_q) begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? (32'd0 - lo_q) : lo_q;
                        exc_d    = dovf_q;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d  = ctrl_MULT ? ST_MULT : ST_DIV;
            cnt_d    = '0;
            acc_d    = 32'd0;
            lo_d     = ctrl_MULT ? data_operandB : magnitude(data_operandA);
            opb_d    = ctrl_MULT ? data_operandA : magnitude(data_operandB);
            neg_d    = data_operandA[31] ^ data_operandB[31];
            dz_d     = (data_operandB == 32'd0);
            dovf_d   = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            result_d = result_q;
            exc_d    = exc_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= 32'd0;
            lo_q     <= 32'd0;
            opb_q    <= 32'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            dovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            dovf_q   <= dovf_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);

endmodule

// File: tb/tb_multdiv.sv
// tb/tb_multdiv.sv - self-checking bench for multdiv against an arithmetic reference model
module tb_multdiv;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int errors = 0;
    int checks = 0;

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns {exception, result}.
    function automatic logic [32:0] model(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
        longint p, q;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p != longint'($signed(p[31:0]))), p[31:0]};
        end
        if (b == 32'd0)
            return {1'b1, 32'd0};
        q = longint'($signed(a)) / longint'($signed(b));
        return {(q > 64'sd2147483647), q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic expect_done(input string tag, input logic [31:0] er, input logic ee);
        int early;
        early = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY !== 1'b0) early++;
            data_operandA = $urandom;
            data_operandB = $urandom;
        end
        check({tag, "_early_rdy"}, 32'(early), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd1);
        check({tag, "_result"}, data_result, er);
        check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, ee});
        @(posedge clock);
        @(negedge clock);
        check({tag, "_rdy_drop"}, {31'b0, data_resultRDY}, 32'd0);
        check({tag, "_held"}, data_result, er);
        check({tag, "_exc_held"}, {31'b0, data_exception}, {31'b0, ee});
    endtask

    task automatic run(input string tag, input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] e;
        e = model(m, a, b);
        issue(m, d, a, b);
        expect_done(tag, e[31:0], e[32]);
    endtask

    initial begin
        int early;
        int t;
        logic        m;
        logic [31:0] a, b;

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'b0, data_exception}, 32'd0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        run("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        check("mul_7x-3_const", data_result, 32'hFFFF_FFEB);
        run("mul_ovf", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd17);
        check("mul_ovf_const", data_result, 32'h7FFF_FFEF);
        run("div_-100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        check("div_-100/7_const", data_result, 32'hFFFF_FFF2);
        run("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0);
        run("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min/-1_const", data_result, 32'h8000_0000);
        run("mul_min*-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run("mul_min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        run("div_7/-100", 1'b0, 1'b1, 32'd7, 32'hFFFF_FF9C);
        run("div_min/min", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        run("mul_priority", 1'b1, 1'b1, 32'd6, 32'd9);

        // Abort: a second start ten cycles in replaces the first operation.
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        early = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY !== 1'b0) early++;
        end
        check("abort_quiet", 32'(early), 32'd0);
        issue(1'b0, 1'b1, 32'd100, 32'd10);
        expect_done("abort_div", 32'd10, 1'b0);

        // Reset mid-operation, start held high while in reset, start on first edge after release.
        issue(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (15) begin
            @(posedge clock);
            @(negedge clock);
        end
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_result", data_result, 32'd0);
        check("rst_mid_exc", {31'b0, data_exception}, 32'd0);
        check("rst_mid_rdy", {31'b0, data_resultRDY}, 32'd0);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_hold_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("rst_hold_result", data_result, 32'd0);
        reset = 1'b0;
        issue(1'b1, 1'b0, 32'd2, 32'd2);
        expect_done("post_rst_2x2", 32'd4, 1'b0);

        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                t = int'($urandom_range(0, 16)) - 8;
                b = t;
            end
            if (m && ($urandom_range(0, 1) == 1)) a = $urandom_range(0, 3000);
            run($sformatf("rand%0d_%s", i, m ? "mul" : "div"), m, ~m, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
